reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
- Trace-side reader of the integer register file. On a `start` pulse it snapshots PC and instruction, then walks x0..x31 through a dedicated register-file read port.
- Emits 34 records over a valid/ready stream: PC header, instruction header, then 32 register beats.
- Sits beside reg_file and replaces simulation-only logging with synthesizable trace output for an external sink (UART/FIFO).
- Asserts `hold` to stall the core while a dump is in progress.

Parameters:
- ARCH_WIDTH, 64, register/data width
- INSTR_WIDTH, 32, instruction width
- PC_WIDTH, 64, program counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle dump request
- pc_in  in  PC_WIDTH  PC sampled on accepted start
- instr_in  in  INSTR_WIDTH  instruction sampled on accepted start
- wb_we  in  1  core writeback enable (same cycle as reg_file we)
- wb_rd  in  5  writeback destination
- wb_data  in  ARCH_WIDTH  writeback data
- rf_addr  out  5  register-file read address
- rf_data  in  ARCH_WIDTH  combinational read data for rf_addr
- hold  out  1  stall request to core; high while busy
- out_valid  out  1  record valid
- out_ready  in  1  sink ready
- out_kind  out  2  0=PC, 1=INSTR, 2=REG
- out_idx  out  5  register index for REG records, else 0
- out_data  out  ARCH_WIDTH  payload, zero-extended
- out_last  out  1  high on the x31 record
- done  out  1  one-cycle pulse after the last record is accepted
- overrun  out  1  sticky: start seen while busy
- wb_err  out  1  sticky: wb_we seen while busy, excluding the start cycle

Behaviour:
- Reset is asynchronous. All outputs go to 0 immediately, FSM goes to IDLE, and any in-flight dump is abandoned with no done pulse.
- FSM states: IDLE, PC, INSTR, REGS, FIN.
- IDLE -> PC on start:
  - Latch pc_in and instr_in.
  - If wb_we && wb_rd != 0, latch a pending bypass (pend_v, pend_rd, pend_data).
- Record timing:
  - Accepted start at edge T: out_valid=1 with PC record by T+1.
  - PC -> INSTR, INSTR -> REGS (idx=0), and REGS idx n -> n+1 each advance only on out_valid && out_ready.
  - REGS idx 31 accepted -> FIN.
  - FIN lasts one cycle: done=1, hold=0 next cycle, then IDLE.
- Throughput: with out_ready held high, 34 beats in 34 consecutive cycles. Last beat accepted at edge T+34; done is high during cycle T+35.
- Output stream stability:
  - out_kind, out_idx, out_data and out_last are registered.
  - They must not change while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- Register read path:
  - rf_addr always presents the index of the next register to be loaded into the output register.
  - The loaded value is selected in priority order:
    - idx 0 -> 0, regardless of rf_data.
    - pend_v && idx == pend_rd -> pend_data.
    - otherwise -> rf_data.
- hold is high from the cycle after an accepted start through FIN inclusive. The core must not write while hold is high; any such wb_we sets wb_err, and the dump continues unchanged.
- Headers: PC record carries the latched PC; INSTR record carries the latched instruction zero-extended to ARCH_WIDTH.
- start while not IDLE: ignored and sets overrun. Sticky flags clear only on rst.
- start and out_ready are independent. Backpressure of any length is legal, with no timeout.

Test Plan:
- Reset, then start with pc_in=0x80000000, instr_in=0x00A00093, rf x5=0x1234, out_ready=1 -> beats PC=0x80000000, INSTR=0x00A00093, REG idx5=0x1234 at cycle T+8, out_last on idx31 at T+34, done pulse at T+35, hold low after.
- Same as above but rf_data for x0 forced to 0xDEAD -> idx0 record reports 0.
- start coincident with wb_we=1, wb_rd=7, wb_data=0xCAFE while reg_file still holds 0 -> idx7 record = 0xCAFE. With wb_rd=0 -> idx0 stays 0, no bypass.
- out_ready toggled 1,0,0,1 pattern during REGS -> payload and idx held stable while stalled; all 34 records delivered once, in order, no gaps or duplicates.
- Second start at idx 10, then wb_we=1 at idx 12 -> overrun=1, wb_err=1, dump completes normally; flags persist until rst.
- rst asserted asynchronously mid-dump at idx 20 -> out_valid, hold and busy drop immediately, no done pulse; a subsequent start produces a full fresh 34-beat dump.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Trace-side register-file dump engine: on start, streams PC, instruction and
// x0..x31 as 34 valid/ready records while stalling the core through hold.
module reg_dump_reader #(
    parameter int ARCH_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   wb_we,
    input  logic [4:0]             wb_rd,
    input  logic [ARCH_WIDTH-1:0]  wb_data,
    output logic [4:0]             rf_addr,
    input  logic [ARCH_WIDTH-1:0]  rf_data,
    output logic                   hold,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_kind,
    output logic [4:0]             out_idx,
    output logic [ARCH_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   done,
    output logic                   overrun,
    output logic                   wb_err
);

    typedef enum logic [2:0] {S_IDLE, S_PC, S_INSTR, S_REGS, S_FIN} state_t;

    localparam logic [1:0] KIND_PC    = 2'd0;
    localparam logic [1:0] KIND_INSTR = 2'd1;
    localparam logic [1:0] KIND_REG   = 2'd2;

    state_t                  state, state_nx;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic                    pend_v;
    logic [4:0]              pend_rd;
    logic [ARCH_WIDTH-1:0]   pend_data;
    logic [4:0]              next_idx;
    logic                    fire;
    logic                    busy;
    logic                    load_reg;
    logic [ARCH_WIDTH-1:0]   reg_value;

    assign fire     = out_valid && out_ready;
    assign busy     = (state != S_IDLE);
    assign load_reg = fire && ((state == S_INSTR) ||
                               ((state == S_REGS) && (out_idx != 5'd31)));
    assign rf_addr  = next_idx;

    // A write captured on the start cycle has not reached reg_file yet, so it
    // is forwarded here instead of the stale rf_data.
    always_comb begin
        reg_value = rf_data;
        if (next_idx == 5'd0)
            reg_value = '0;
        else if (pend_v && (next_idx == pend_rd))
            reg_value = pend_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // NOTE: next-state gets a default before the case so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_PC;
            S_PC:    if (fire) state_nx = S_INSTR;
            S_INSTR: if (fire) state_nx = S_REGS;
            S_REGS:  if (fire && (out_idx == 5'd31)) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            wb_err  <= 1'b0;
        end else begin
            if (start && busy) overrun <= 1'b1;
            if (wb_we && busy) wb_err  <= 1'b1;
        end
    end

    // NOTE: output stream registers only move on a handshake, which keeps the
    // payload stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_kind  <= KIND_PC;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            hold      <= 1'b0;
            instr_q   <= '0;
            next_idx  <= '0;
            pend_v    <= 1'b0;
            pend_rd   <= '0;
            pend_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        out_valid <= 1'b1;
                        out_kind  <= KIND_PC;
                        out_idx   <= '0;
                        out_data  <= ARCH_WIDTH'(pc_in);
                        out_last  <= 1'b0;
                        hold      <= 1'b1;
                        instr_q   <= instr_in;
                        next_idx  <= '0;
                        pend_v    <= wb_we && (wb_rd != 5'd0);
                        pend_rd   <= wb_rd;
                        pend_data <= wb_data;
                    end
                end
                S_PC: begin
                    if (fire) begin
                        out_kind <= KIND_INSTR;
                        out_data <= ARCH_WIDTH'(instr_q);
                    end
                end
                S_INSTR, S_REGS: begin
                    if (load_reg) begin
                        out_kind <= KIND_REG;
                        out_idx  <= next_idx;
                        out_data <= reg_value;
                        out_last <= (next_idx == 5'd31);
                        next_idx <= next_idx + 5'd1;
                    end else if (fire) begin
                        out_valid <= 1'b0;
                        out_kind  <= KIND_PC;
                        out_idx   <= '0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                S_FIN: begin
                    hold   <= 1'b0;
                    pend_v <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: directed and randomized dumps are
// compared against a record list derived from the dump rules.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic        hold;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_kind;
    logic [4:0]  out_idx;
    logic [63:0] out_data;
    logic        out_last;
    logic        done;
    logic        overrun;
    logic        wb_err;

    logic [63:0] rf_mem [32];
    assign rf_data = rf_mem[rf_addr];

    reg_dump_reader #(.ARCH_WIDTH(64), .INSTR_WIDTH(32), .PC_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .instr_in(instr_in),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .rf_addr(rf_addr),
        .rf_data(rf_data), .hold(hold), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_idx(out_idx), .out_data(out_data),
        .out_last(out_last), .done(done), .overrun(overrun), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
        int          edge_n;
    } beat_t;

    beat_t beats[$];
    beat_t exp_q[$];
    int    done_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: handshakes seen at the falling edge complete on the next rising edge.
    logic        stall_prev = 1'b0;
    logic [79:0] held = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stable_under_stall", {out_valid, out_kind, out_idx, out_last, out_data}, held);
            stall_prev = out_valid && !out_ready;
            held = {out_valid, out_kind, out_idx, out_last, out_data};
            if (out_valid && out_ready)
                beats.push_back('{out_kind, out_idx, out_data, out_last, cyc + 1});
            if (done) begin
                done_q.push_back(cyc + 1);
                check("hold_during_fin", hold, 1);
            end
        end
    end

    task automatic build_expected(input logic [63:0] pc, input logic [31:0] ins,
                                  input logic we, input logic [4:0] rd, input logic [63:0] wd);
        logic [63:0] v;
        exp_q.delete();
        exp_q.push_back('{2'd0, 5'd0, pc, 1'b0, 0});
        exp_q.push_back('{2'd1, 5'd0, {32'd0, ins}, 1'b0, 0});
        for (int i = 0; i < 32; i++) begin
            if (i == 0)                      v = 64'd0;
            else if (we && rd != 0 && i == rd) v = wd;
            else                             v = rf_mem[i];
            exp_q.push_back('{2'd2, 5'(i), v, (i == 31), 0});
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            case (k % 4)
                0, 3:    return 1'b1;
                default: return 1'b0;
            endcase
        end
        return 1'($urandom_range(0, 1));
    endfunction

    // mode: 0 ready high, 1 pattern 1,0,0,1, 2 random. inject: second start and stray write mid-dump.
    task automatic run_dump(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                            input logic we, input logic [4:0] rd, input logic [63:0] wd,
                            input int mode, input bit inject);
        int  t0;
        int  k;
        bit  did_start;
        bit  did_we;
        beats.delete();
        done_q.delete();
        build_expected(pc, ins, we, rd, wd);
        @(posedge clk); #1;
        start = 1'b1; pc_in = pc; instr_in = ins; wb_we = we; wb_rd = rd; wb_data = wd;
        @(posedge clk); #1;
        t0 = cyc;
        k = 0; did_start = 0; did_we = 0;
        while (done_q.size() == 0 && k < 3000) begin
            start = 1'b0; wb_we = 1'b0;
            out_ready = ready_for(mode, k);
            if (inject && !did_start && beats.size() == 12) begin
                start = 1'b1; pc_in = {$urandom, $urandom}; did_start = 1;
            end
            if (inject && !did_we && beats.size() == 14) begin
                wb_we = 1'b1; wb_rd = 5'd12; wb_data = {$urandom, $urandom}; did_we = 1;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0; wb_we = 1'b0;
        check({tag, "_done_seen"}, (done_q.size() == 1), 1);
        @(negedge clk);
        check({tag, "_idle_after"}, {hold, out_valid}, 0);
        check({tag, "_beat_count"}, beats.size(), 34);
        if (beats.size() == 34) begin
            for (int i = 0; i < 34; i++)
                check($sformatf("%s_beat%0d", tag, i),
                      {beats[i].kind, beats[i].idx, beats[i].last, beats[i].data},
                      {exp_q[i].kind, exp_q[i].idx, exp_q[i].last, exp_q[i].data});
            if (mode == 0) begin
                check({tag, "_idx5_edge"}, beats[7].edge_n, t0 + 8);
                check({tag, "_last_edge"}, beats[33].edge_n, t0 + 34);
                if (done_q.size() > 0)
                    check({tag, "_done_edge"}, done_q[0], t0 + 35);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic run_abort();
        int k;
        beats.delete();
        done_q.delete();
        @(posedge clk); #1;
        start = 1'b1; pc_in = {$urandom, $urandom}; instr_in = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (beats.size() < 22 && k < 500) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        check("abort_reached_idx20", beats.size(), 22);
        #2 rst = 1'b1;
        #1 check("abort_async_drop", {out_valid, hold, done, rf_addr}, 0);
        repeat (3) @(posedge clk);
        #1 check("abort_no_done", done_q.size(), 0);
        check("abort_flags_clear", {overrun, wb_err}, 0);
        rst = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        #1;
        check("reset_outputs", {hold, out_valid, done, overrun, wb_err, out_last,
                                out_kind, out_idx, rf_addr}, 0);
        check("reset_data", out_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        rf_mem[0] = 64'd0;
        rf_mem[5] = 64'h1234;
        run_dump("basic", 64'h8000_0000, 32'h00A0_0093, 0, 5'd0, 64'd0, 0, 0);

        rf_mem[0] = 64'hDEAD;
        run_dump("x0_forced", 64'h8000_0000, 32'h00A0_0093, 0, 5'd0, 64'd0, 0, 0);

        rf_mem[7] = 64'd0;
        run_dump("bypass7", 64'h8000_0010, 32'h0070_0393, 1, 5'd7, 64'hCAFE, 0, 0);
        run_dump("bypass0", 64'h8000_0020, 32'h0000_0013, 1, 5'd0, 64'hBEEF, 0, 0);
        check("no_flags_from_start_cycle", {overrun, wb_err}, 0);

        for (int i = 1; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        run_dump("ready_1001", {$urandom, $urandom}, $urandom, 0, 5'd0, 64'd0, 1, 0);

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
            run_dump($sformatf("rand%0d", n), {$urandom, $urandom}, $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     {$urandom, $urandom}, 2, 0);
        end
        check("rand_no_flags", {overrun, wb_err}, 0);

        run_dump("inject", {$urandom, $urandom}, $urandom, 0, 5'd0, 64'd0, 0, 1);
        check("overrun_set", overrun, 1);
        check("wb_err_set", wb_err, 1);
        run_dump("after_inject", {$urandom, $urandom}, $urandom, 0, 5'd0, 64'd0, 2, 0);
        check("flags_sticky", {overrun, wb_err}, 2'b11);

        run_abort();
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        run_dump("fresh", {$urandom, $urandom}, $urandom, 1, 5'd31, {$urandom, $urandom}, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
